// File: rtl/scrambled_app_ram.sv
// 128 KiB application RAM with per-session XOR scrambling of address and data.
// Single-cycle cs/ready bus slave; keys are sampled in the access cycle.
module scrambled_app_ram #(
    parameter int ADDR_BITS = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] ram_addr_rand,
    input  logic [31:0]          ram_data_rand,
    input  logic                 cs,
    input  logic [3:0]           we,
    input  logic [15:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] logical_addr;
    logic [ADDR_BITS-1:0] phys_addr;
    logic [31:0]          data_mask;
    logic [31:0]          scrambled_wdata;
    logic                 unused_addr_bits;

    assign logical_addr     = address[ADDR_BITS-1:0];
    assign unused_addr_bits = ^address[15:ADDR_BITS];

    // The mask folds in the logical address so identical data at different
    // addresses never looks identical in the physical array.
    assign phys_addr       = logical_addr ^ ram_addr_rand;
    assign data_mask       = ram_data_rand ^ {{(32 - ADDR_BITS){1'b0}}, logical_addr};
    assign scrambled_wdata = write_data ^ data_mask;

    always_ff @(posedge clk) begin
        if (cs && (we != 4'h0)) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[phys_addr][8*i +: 8] <= scrambled_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready     <= 1'b0;
            read_data <= 32'h0;
        end else begin
            ready <= cs;
            if (cs && (we == 4'h0)) begin
                read_data <= mem[phys_addr] ^ data_mask;
            end
        end
    end

endmodule

// File: tb/tb_scrambled_app_ram.sv
// Directed self-checking bench for scrambled_app_ram: round-trip, byte lanes,
// key change, handshake timing and asynchronous reset.
module tb_scrambled_app_ram;

    logic        clk;
    logic        reset_n;
    logic [14:0] ram_addr_rand;
    logic [31:0] ram_data_rand;
    logic        cs;
    logic [3:0]  we;
    logic [15:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    int testCount = 0;
    int failCount = 0;

    scrambled_app_ram #(.ADDR_BITS(15)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ram_addr_rand (ram_addr_rand),
        .ram_data_rand (ram_data_rand),
        .cs            (cs),
        .we            (we),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access: drive on a falling edge, return on the next falling edge
    // so the registered outputs of that access are visible.
    task automatic applyStimulus(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        cs         = 1'b1;
        we         = w;
        address    = a;
        write_data = d;
        @(negedge clk);
        cs         = 1'b0;
        we         = 4'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        ram_addr_rand = 15'h0;
        ram_data_rand = 32'h0;
        cs            = 1'b0;
        we            = 4'h0;
        address       = 16'h0;
        write_data    = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'b0, ready}, 32'h0);
        checkOutput("reset_rdata", read_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", {31'b0, ready}, 32'h0);

        // Keys zero: plain round trip
        applyStimulus(16'h0010, 4'hF, 32'hDEADBEEF);
        checkOutput("write_ready", {31'b0, ready}, 32'h1);
        checkOutput("write_no_rdata", read_data, 32'h0);
        applyStimulus(16'h0010, 4'h0, 32'h0);
        checkOutput("k0_ready", {31'b0, ready}, 32'h1);
        checkOutput("k0_rdata", read_data, 32'hDEADBEEF);
        applyStimulus(16'h8010, 4'h0, 32'h0);
        checkOutput("addr_bit15_ignored", read_data, 32'hDEADBEEF);

        // Non-zero keys at the top address
        ram_addr_rand = 15'h1234;
        ram_data_rand = 32'hA5A5A5A5;
        applyStimulus(16'h7FFF, 4'hF, 32'h01234567);
        applyStimulus(16'h7FFF, 4'h0, 32'h0);
        checkOutput("key_rdata", read_data, 32'h01234567);
        checkOutput("key_peek", dut.mem[15'h6DCB], 32'hA4869F3D);

        // Byte lanes under the same keys
        applyStimulus(16'h0020, 4'hF, 32'h11223344);
        applyStimulus(16'h0020, 4'b0101, 32'hAABBCCDD);
        applyStimulus(16'h0020, 4'h0, 32'h0);
        checkOutput("byte_lanes", read_data, 32'h11BB33DD);

        // Key change reads back scrambled data
        ram_addr_rand = 15'h0;
        ram_data_rand = 32'h0;
        applyStimulus(16'h0100, 4'hF, 32'hCAFEBABE);
        ram_data_rand = 32'hFFFFFFFF;
        applyStimulus(16'h0100, 4'h0, 32'h0);
        checkOutput("key_change", read_data, 32'h35014541);

        // Handshake: cs every other cycle, ready follows one cycle later
        ram_data_rand = 32'h0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0010, 4'h0, 32'h0);
            checkOutput("pulse_ready_hi", {31'b0, ready}, 32'h1);
            checkOutput("pulse_rdata", read_data, 32'hDEADBEEF);
            @(negedge clk);
            checkOutput("pulse_ready_lo", {31'b0, ready}, 32'h0);
            checkOutput("idle_rdata_hold", read_data, 32'hDEADBEEF);
        end

        // cs held high keeps ready high
        @(negedge clk);
        cs      = 1'b1;
        we      = 4'h0;
        address = 16'h0010;
        @(negedge clk);
        checkOutput("held_ready_1", {31'b0, ready}, 32'h1);
        @(negedge clk);
        checkOutput("held_ready_2", {31'b0, ready}, 32'h1);
        checkOutput("held_rdata", read_data, 32'hDEADBEEF);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", {31'b0, ready}, 32'h0);
        checkOutput("async_rst_rdata", read_data, 32'h0);
        cs = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'b0, ready}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/scrambled_app_ram.md
Name: scrambled_app_ram

Overview:
- 128 KiB application RAM: 32768 x 32-bit words, byte-writable, on the CPU memory bus.
- Used for the RAM area, CPU address bits [31:30] = 2'b01.
- Address and data are XOR-scrambled with per-session random values supplied by the tk1 core. Scrambling is transparent to the CPU while the random values stay constant.
- Single-cycle cs/ready handshake, matching the other bus slaves.

Parameters:
- ADDR_BITS, 15, word-address width (depth = 2**ADDR_BITS words).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ram_addr_rand  in  15  address scramble key
- ram_data_rand  in  32  data scramble key
- cs  in  1  access strobe, one cycle per access
- we  in  4  byte write enables; we[i] covers write_data[8i+7:8i]; 4'h0 = read
- address  in  16  word address; bits [14:0] used, bit 15 ignored
- write_data  in  32  write data
- read_data  out  32  read data, valid while ready=1
- ready  out  1  access complete

Behaviour:
- Reset is asynchronous, active-low; one clock domain, all outputs registered.
- On reset: ready=0, read_data=0. Memory contents are not cleared (undefined after power-up).
- Physical address: phys = address[14:0] XOR ram_addr_rand.
- Data mask: mask = ram_data_rand XOR {17'b0, address[14:0]}, built from the unscrambled logical address.
- Write (cs=1, we!=0): for each i with we[i]=1, store byte lane i of (write_data XOR mask) at mem[phys]. Lanes with we[i]=0 are unchanged.
- Read (cs=1, we=0): on the next clock edge, read_data <= mem[phys] XOR mask.
- Write cycles: read_data is not updated.
- ready <= cs on every clock edge (1-cycle latency).
  - ready=1 exactly one cycle after each cs cycle.
  - If cs is held high, ready stays high.
- cs=0: no memory access; read_data holds its last value; ready=0 on the next cycle.
- Logical round-trip: with keys constant, a read of address A returns the last data written to A (per byte lane).
- Key change: after either key changes, earlier data reads back scrambled; no error is flagged.
- Scrambling hides layout, not access: distinct logical addresses always map to distinct physical words (XOR is a bijection).
- Simultaneous read/write is impossible: a single port, so we decides the access type.
- Reset asserted mid-access:
  - ready and read_data clear immediately.
  - A write on the same edge may or may not commit.
- Key inputs are sampled in the same cycle as cs; they are not registered internally.
- Implementation:
  - May use 4 banks of 16-bit-wide single-port RAM (e.g. SPRAM pairs); behaviour must be identical.
  - Simulation must use a behavioural array.

Test Plan:
- Keys = 0: write 32'hDEADBEEF at address 0x0010 with we=4'hF, then read 0x0010 → ready=1 one cycle after cs, read_data=32'hDEADBEEF.
- Keys 15'h1234 / 32'hA5A5A5A5:
  - write 32'h01234567 at 0x7FFF → read 0x7FFF returns 32'h01234567.
  - Hierarchical peek of mem[0x7FFF^0x1234] = 32'h01234567^32'hA5A5A5A5^32'h00007FFF.
- Byte lanes: write 32'h11223344 at 0x0020, then write 32'hAABBCCDD with we=4'b0101 → read returns 32'h11BB33DD.
- Key change: write 32'hCAFEBABE at 0x0100 under key 32'h0, switch ram_data_rand to 32'hFFFFFFFF → read returns 32'h35014541.
- Handshake:
  - cs pulses every other cycle → ready pulses exactly one cycle later each time.
  - cs=0 → ready=0 and read_data unchanged.
- Reset: assert reset_n=0 between clock edges while ready=1 → ready and read_data go to 0 immediately, without waiting for a clock edge.
